// File: rtl/dynode_arb_pkg.sv
// Shared types and the round-robin search for the dynode trigger arbiter.
// Slot records carry a fixed-width age field; users truncate to their AGE_W.
package dynode_arb_pkg;

  localparam int OFFSET_W = 6;
  localparam int AGE_WM   = 16;
  localparam int MAX_CH   = 16;

  typedef struct packed {
    logic                valid;
    logic [OFFSET_W-1:0] offset;
    logic [AGE_WM-1:0]   age;
    logic                coinc;
  } slot_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_t;

  // First set bit of req searching upward from ptr+1, wrapping modulo n.
  function automatic rr_t rr_next(
    input logic [MAX_CH-1:0] req,
    input logic [3:0]        ptr,
    input int                n
  );
    rr_t r;
    int  j;
    r = '0;
    for (int k = 1; k <= MAX_CH; k++) begin
      j = (int'(ptr) + k) % n;
      if (k <= n && !r.found && req[4'(j)]) begin
        r.found = 1'b1;
        r.idx   = 4'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dynode_arb_slot.sv
// One channel: pending slot, age, holdoff and saturating drop counter.
// Coincidence ports exist only when DYNODE_ARB_COINC_EN is defined.
module dynode_arb_slot
  import dynode_arb_pkg::*;
#(
  parameter int AGE_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                strobe,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [AGE_W-1:0]    holdoff,
  input  logic [AGE_W-1:0]    max_age,
  input  logic                clear_counts,
  input  logic                grant,
`ifdef DYNODE_ARB_COINC_EN
  input  logic                coinc,
  output logic                hit,
`endif
  output logic                full,
  output slot_t               slot,
  output logic [DROP_W-1:0]   drop_count
);

  logic [AGE_W-1:0]  hold_cnt;
  logic [AGE_WM-1:0] age_top;
  logic [AGE_WM-1:0] age_lim;
  logic              accept;
  logic              take;
  logic              lost;
  logic              expire;
  logic [1:0]        inc;
  logic [DROP_W:0]   sum;

  assign age_top = AGE_WM'({AGE_W{1'b1}});
  assign age_lim = AGE_WM'(max_age);
  assign accept  = strobe && (hold_cnt == '0);
  assign full    = slot.valid;
  assign expire  = slot.valid && !grant &&
                   (max_age != '0) && (slot.age == age_lim);
  // A slot being granted this tick can take a new word.
  assign take    = accept && (!slot.valid || grant);
  assign lost    = accept && slot.valid && !grant;
  assign inc     = {1'b0, lost} + {1'b0, expire};
  assign sum     = {1'b0, drop_count} + (DROP_W+1)'(inc);

`ifdef DYNODE_ARB_COINC_EN
  assign hit = accept;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      slot       <= '0;
      hold_cnt   <= '0;
      drop_count <= '0;
    end else begin
      if (accept)
        hold_cnt <= holdoff;
      else if (hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;

      if (take) begin
        slot.valid  <= 1'b1;
        slot.offset <= offset;
        slot.age    <= '0;
`ifdef DYNODE_ARB_COINC_EN
        slot.coinc  <= coinc;
`else
        slot.coinc  <= 1'b0;
`endif
      end else if (grant || expire) begin
        slot <= '0;
      end else if (slot.valid && slot.age != age_top) begin
        slot.age <= slot.age + 1'b1;
      end

      if (clear_counts)
        drop_count <= '0;
      else if (inc != 2'd0)
        drop_count <= sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    end
  end

endmodule

// File: rtl/dynode_trigger_arbiter.sv
// Round-robin serialiser of per-channel dynode trigger words.
// Define DYNODE_ARB_COINC_EN to add the trig_coinc output.
module dynode_trigger_arbiter
  import dynode_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int CW     = $clog2(NCH),
  parameter int AGE_W  = 4,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        single,
  input  logic [6*NCH-1:0]      offset,
  input  logic [NCH-1:0]        chan_enable,
  input  logic [AGE_W-1:0]      holdoff,
  input  logic [AGE_W-1:0]      max_age,
  input  logic                  clear_counts,
  output logic                  trig_valid,
  input  logic                  trig_ready,
  output logic [CW-1:0]         trig_chan,
  output logic [5:0]            trig_offset,
  output logic [AGE_W-1:0]      trig_age,
  output logic [DROP_W*NCH-1:0] drop_count
`ifdef DYNODE_ARB_COINC_EN
  ,
  output logic                  trig_coinc
`endif
);

  slot_t           slots [NCH];
  logic [NCH-1:0]  full;
  logic [NCH-1:0]  grant;
  logic [CW-1:0]   rr_ptr;
  logic [CW-1:0]   sel;
  logic            advance;
  rr_t             pick;

  assign advance = !trig_valid || trig_ready;
  assign pick    = rr_next(MAX_CH'(full), 4'(rr_ptr), NCH);
  assign sel     = CW'(pick.idx);

  always_comb begin
    grant = '0;
    if (advance && pick.found)
      grant[sel] = 1'b1;
  end

`ifdef DYNODE_ARB_COINC_EN
  logic [NCH-1:0] hit;
  logic [NCH-1:0] coinc;

  // A capture is coincident when any other channel accepted a strobe.
  always_comb begin
    coinc = '0;
    for (int i = 0; i < NCH; i++)
      coinc[i] = |(hit & ~(NCH'(1) << i));
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    dynode_arb_slot #(
      .AGE_W  (AGE_W),
      .DROP_W (DROP_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .strobe       (single[i] && chan_enable[i]),
      .offset       (offset[OFFSET_W*i +: OFFSET_W]),
      .holdoff      (holdoff),
      .max_age      (max_age),
      .clear_counts (clear_counts),
      .grant        (grant[i]),
`ifdef DYNODE_ARB_COINC_EN
      .coinc        (coinc[i]),
      .hit          (hit[i]),
`endif
      .full         (full[i]),
      .slot         (slots[i]),
      .drop_count   (drop_count[DROP_W*i +: DROP_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_valid  <= 1'b0;
      trig_chan   <= '0;
      trig_offset <= '0;
      trig_age    <= '0;
      rr_ptr      <= CW'(NCH-1);
`ifdef DYNODE_ARB_COINC_EN
      trig_coinc  <= 1'b0;
`endif
    end else if (advance) begin
      trig_valid <= pick.found;
      if (pick.found) begin
        trig_chan   <= sel;
        trig_offset <= slots[sel].offset;
        trig_age    <= AGE_W'(slots[sel].age);
        rr_ptr      <= sel;
`ifdef DYNODE_ARB_COINC_EN
        trig_coinc  <= slots[sel].coinc;
`endif
      end
    end
  end

endmodule
